// File: rtl/corexy_step_decoder.sv
// corexy_step_decoder: decodes two step/dir pulse trains into A/B/X/Y positions and step periods with a req/ack snapshot port
module corexy_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 4,
  parameter int TIMEOUT     = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_1,
  input  logic        dir_1,
  input  logic        step_2,
  input  logic        dir_2,
  input  logic        clear,
  input  logic        snap_req,
  output logic        snap_ack,
  output logic [31:0] pos_a,
  output logic [31:0] pos_b,
  output logic [31:0] pos_x,
  output logic [31:0] pos_y,
  output logic [31:0] period_1,
  output logic [31:0] period_2,
  output logic [15:0] glitch_cnt,
  output logic        moving
);
  localparam int RW = $clog2(MIN_PULSE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {LOW, PEND, HIGH} filt_e;
  logic [SYNC_STAGES-1:0] sa_q, da_q, sb_q, db_q;
  logic [1:0]    step_s, dir_s, acc, rej;
  filt_e         st_q [2];
  filt_e         st_d [2];
  logic [RW-1:0] run_q [2];
  logic [RW-1:0] run_d [2];
  logic [TW-1:0] ival_q [2];
  logic [TW-1:0] ival_d [2];
  logic [TW-1:0] ival_inc [2];
  logic [31:0]   per_q [2];
  logic [31:0]   per_d [2];
  logic [1:0]    idle_q, idle_d;
  logic [31:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [15:0]   glitch_q, glitch_d;
  logic [16:0]   glitch_sum;
  logic [31:0]   x_live, y_live;
  logic          snap_ack_q, cap;
  logic [31:0]   pos_a_q, pos_b_q, pos_x_q, pos_y_q, period_1_q, period_2_q;
  logic [15:0]   glitch_cnt_q;
  assign step_s = {sb_q[SYNC_STAGES-1], sa_q[SYNC_STAGES-1]};
  assign dir_s  = {db_q[SYNC_STAGES-1], da_q[SYNC_STAGES-1]};
  // Metastability chains on the asynchronous step/dir inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q <= '0;
      da_q <= '0;
      sb_q <= '0;
      db_q <= '0;
    end else begin
      sa_q <= {sa_q[SYNC_STAGES-2:0], step_1};
      da_q <= {da_q[SYNC_STAGES-2:0], dir_1};
      sb_q <= {sb_q[SYNC_STAGES-2:0], step_2};
      db_q <= {db_q[SYNC_STAGES-2:0], dir_2};
    end
  end
  // Pulse-width filter: accept once per high phase after MIN_PULSE high clocks, reject shorter pulses
  always_comb begin
    acc = '0;
    rej = '0;
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      run_d[i] = run_q[i];
      case (st_q[i])
        LOW: if (step_s[i]) begin
          run_d[i] = RW'(1);
          acc[i]   = (MIN_PULSE <= 1);
          st_d[i]  = (MIN_PULSE <= 1) ? HIGH : PEND;
        end
        PEND: if (!step_s[i]) begin
          rej[i]  = 1'b1;
          st_d[i] = LOW;
        end else begin
          run_d[i] = run_q[i] + RW'(1);
          acc[i]   = (run_d[i] == RW'(MIN_PULSE));
          st_d[i]  = acc[i] ? HIGH : PEND;
        end
        HIGH: st_d[i] = step_s[i] ? HIGH : LOW;
        default: st_d[i] = LOW;
      endcase
    end
  end
  // Interval counters, period capture and idle detection; clear overrides everything
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ival_inc[i] = (ival_q[i] == TW'(TIMEOUT)) ? ival_q[i] : ival_q[i] + TW'(1);
      ival_d[i]   = (clear | acc[i]) ? '0 : ival_inc[i];
      idle_d[i]   = clear | (~acc[i] & (idle_q[i] | (ival_inc[i] == TW'(TIMEOUT))));
      per_d[i]    = (clear | (~acc[i] & (ival_inc[i] == TW'(TIMEOUT)))) ? '0 :
                    (acc[i] & ~idle_q[i]) ? 32'(ival_inc[i]) : per_q[i];
    end
  end
  assign cnt_a_d    = clear ? '0 : acc[0] ? (dir_s[0] ? cnt_a_q - 32'd1 : cnt_a_q + 32'd1) : cnt_a_q;
  assign cnt_b_d    = clear ? '0 : acc[1] ? (dir_s[1] ? cnt_b_q - 32'd1 : cnt_b_q + 32'd1) : cnt_b_q;
  assign glitch_sum = {1'b0, glitch_q} + 17'(rej[0]) + 17'(rej[1]);
  assign glitch_d   = clear ? '0 : glitch_sum[16] ? 16'hFFFF : glitch_sum[15:0];
  // floor((A+B)/2) and floor((A-B)/2) built from halved operands plus the lost low-bit carry/borrow
  assign x_live = {cnt_a_q[31], cnt_a_q[31:1]} + {cnt_b_q[31], cnt_b_q[31:1]} + {31'b0, cnt_a_q[0] & cnt_b_q[0]};
  assign y_live = {cnt_a_q[31], cnt_a_q[31:1]} - {cnt_b_q[31], cnt_b_q[31:1]} - {31'b0, ~cnt_a_q[0] & cnt_b_q[0]};
  // Live channel state: filter FSMs, counters, periods, glitch count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= LOW;
        run_q[i]  <= '0;
        ival_q[i] <= '0;
        per_q[i]  <= '0;
      end
      idle_q   <= 2'b11;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      glitch_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= st_d[i];
        run_q[i]  <= run_d[i];
        ival_q[i] <= ival_d[i];
        per_q[i]  <= per_d[i];
      end
      idle_q   <= idle_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      glitch_q <= glitch_d;
    end
  end
  assign cap = snap_req & ~snap_ack_q;
  // Four-phase snapshot: capture pre-edge live values when a new request arrives, hold while acked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_ack_q   <= 1'b0;
      pos_a_q      <= '0;
      pos_b_q      <= '0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      period_1_q   <= '0;
      period_2_q   <= '0;
      glitch_cnt_q <= '0;
    end else begin
      snap_ack_q <= snap_req;
      if (cap) begin
        pos_a_q      <= cnt_a_q;
        pos_b_q      <= cnt_b_q;
        pos_x_q      <= x_live;
        pos_y_q      <= y_live;
        period_1_q   <= per_q[0];
        period_2_q   <= per_q[1];
        glitch_cnt_q <= glitch_q;
      end
    end
  end
  assign snap_ack   = snap_ack_q;
  assign pos_a      = pos_a_q;
  assign pos_b      = pos_b_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign period_1   = period_1_q;
  assign period_2   = period_2_q;
  assign glitch_cnt = glitch_cnt_q;
  assign moving     = ~&idle_q;
endmodule

// File: tb/tb_corexy_step_decoder.sv
// tb_corexy_step_decoder: directed scoreboard bench for the CoreXY step decoder
module tb_corexy_step_decoder;
  localparam int TO = 200;
  typedef struct {
    logic [31:0] a, b, x, y, p1, p2;
    logic [15:0] g;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic step_1 = 1'b0, dir_1 = 1'b0, step_2 = 1'b0, dir_2 = 1'b0;
  logic clear = 1'b0, snap_req = 1'b0;
  logic snap_ack, moving;
  logic [31:0] pos_a, pos_b, pos_x, pos_y, period_1, period_2;
  logic [15:0] glitch_cnt;
  int npass = 0, ntotal = 0;
  exp_t sb [$];
  corexy_step_decoder #(.SYNC_STAGES(2), .MIN_PULSE(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .step_1(step_1), .dir_1(dir_1), .step_2(step_2), .dir_2(dir_2),
    .clear(clear), .snap_req(snap_req), .snap_ack(snap_ack), .pos_a(pos_a), .pos_b(pos_b),
    .pos_x(pos_x), .pos_y(pos_y), .period_1(period_1), .period_2(period_2),
    .glitch_cnt(glitch_cnt), .moving(moving)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask
  task automatic cmp(input string tag, input exp_t e);
    chk({tag, " pos_a"}, pos_a, e.a);
    chk({tag, " pos_b"}, pos_b, e.b);
    chk({tag, " pos_x"}, pos_x, e.x);
    chk({tag, " pos_y"}, pos_y, e.y);
    chk({tag, " period_1"}, period_1, e.p1);
    chk({tag, " period_2"}, period_2, e.p2);
    chk({tag, " glitch"}, {16'b0, glitch_cnt}, {16'b0, e.g});
  endtask
  task automatic pulse(input logic e1, input logic e2, input logic d1, input logic d2, input int hi, input int lo);
    dir_1 = d1;
    dir_2 = d2;
    step_1 = e1;
    step_2 = e2;
    repeat (hi) @(negedge clk);
    step_1 = 1'b0;
    step_2 = 1'b0;
    repeat (lo) @(negedge clk);
  endtask
  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask
  task automatic snap(input string tag);
    exp_t e;
    int n = 0;
    snap_req = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!snap_ack && n < 20);
    chk({tag, " ack_latency"}, 32'(n), 32'd1);
    e = sb.pop_front();
    if (snap_ack) cmp(tag, e);
    @(negedge clk);
    snap_req = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " ack_fall"}, {31'b0, snap_ack}, 32'd0);
    @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk("reset pos_a", pos_a, 0);
    chk("reset pos_x", pos_x, 0);
    chk("reset period_1", period_1, 0);
    chk("reset glitch", {16'b0, glitch_cnt}, 0);
    chk("reset ack", {31'b0, snap_ack}, 0);
    chk("reset moving", {31'b0, moving}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) pulse(1, 0, 0, 0, 8, 12);
    chk("train moving", {31'b0, moving}, 1);
    sb.push_back('{32'd10, 32'd0, 32'd5, 32'd5, 32'd20, 32'd0, 16'd0});
    snap("fwd10");
    do_clear();
    for (int i = 0; i < 3; i++) pulse(1, 1, 1, 1, 8, 12);
    sb.push_back('{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd0, 32'd20, 32'd20, 16'd0});
    snap("rev3");
    do_clear();
    for (int i = 0; i < 5; i++) pulse(1, 0, 0, 0, 2, 8);
    pulse(1, 1, 0, 0, 2, 8);
    pulse(1, 0, 0, 0, 100, 10);
    sb.push_back('{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd7});
    snap("glitch");
    do_clear();
    force dut.cnt_a_q = 32'h7FFFFFFF;
    repeat (2) @(negedge clk);
    release dut.cnt_a_q;
    pulse(1, 0, 0, 0, 8, 12);
    sb.push_back('{32'h80000000, 32'd0, 32'hC0000000, 32'hC0000000, 32'd0, 32'd0, 16'd0});
    snap("wrap");
    do_clear();
    for (int i = 0; i < 3; i++) pulse(1, 0, 0, 0, 8, 42);
    step_1 = 1'b1;
    repeat (8) @(negedge clk);
    step_1 = 1'b0;
    repeat (TO - 3) @(posedge clk);
    #1;
    chk("timeout-1 moving", {31'b0, moving}, 1);
    @(posedge clk);
    #1;
    chk("timeout moving", {31'b0, moving}, 0);
    @(negedge clk);
    sb.push_back('{32'd4, 32'd0, 32'd2, 32'd2, 32'd0, 32'd0, 16'd0});
    snap("timeout");
    step_1 = 1'b1;
    repeat (5) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    step_1 = 1'b0;
    repeat (8) @(negedge clk);
    sb.push_back('{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd0});
    snap("clear_wins");
    do_clear();
    for (int i = 0; i < 2; i++) pulse(1, 0, 0, 0, 8, 12);
    sb.push_back('{32'd2, 32'd0, 32'd1, 32'd1, 32'd20, 32'd0, 16'd0});
    snap_req = 1'b1;
    step_1 = 1'b1;
    @(posedge clk);
    #1;
    chk("hold ack_rise", {31'b0, snap_ack}, 1);
    e = sb.pop_front();
    cmp("hold", e);
    repeat (8) @(negedge clk);
    step_1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold frozen pos_a", pos_a, 2);
    chk("hold ack_high", {31'b0, snap_ack}, 1);
    snap_req = 1'b0;
    @(posedge clk);
    #1;
    chk("hold ack_fall", {31'b0, snap_ack}, 0);
    @(negedge clk);
    sb.push_back('{32'd3, 32'd0, 32'd1, 32'd1, 32'd20, 32'd0, 16'd0});
    snap("recapture");
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
